// File: rtl/power_sequencer_fsm.sv
// power_sequencer_fsm
// Holds main system power through an external D-FF, brings up NUM_RAILS rails
// in order with a power-good timeout per rail, and takes them down again in
// reverse order on a soft request or long button press, or all at once on a
// rail fault. After power-down the D-FF is cleared and kept clocked until the
// supply collapses.
module power_sequencer_fsm #(
  parameter int CLK_HZ            = 100000000,
  parameter int NUM_RAILS         = 3,
  parameter int ON_PRESS_MS       = 1000,
  parameter int OFF_PRESS_MS      = 5000,
  parameter int RAIL_STEP_US      = 1000,
  parameter int PGOOD_TIMEOUT_MS  = 50,
  parameter int FD_SETUP_HOLD_CYC = 100
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 btn_pressed,
  input  logic                 pwr_off_req,
  input  logic [NUM_RAILS-1:0] pgood,
  output logic                 fd_clk,
  output logic                 fd_dat,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 pwr_ready,
  output logic                 fault,
  output logic [2:0]           fault_rail
);

  localparam logic [31:0] T_ON      = 32'(CLK_HZ / 1000 * ON_PRESS_MS);
  localparam logic [31:0] T_OFF     = 32'(CLK_HZ / 1000 * OFF_PRESS_MS);
  localparam logic [31:0] T_STEP    = 32'(CLK_HZ / 1000000 * RAIL_STEP_US);
  localparam logic [31:0] T_PG      = 32'(CLK_HZ / 1000 * PGOOD_TIMEOUT_MS);
  localparam logic [31:0] T_FD      = 32'(FD_SETUP_HOLD_CYC);
  localparam logic [2:0]  LAST_RAIL = 3'(NUM_RAILS - 1);

  if (CLK_HZ < 1000 || CLK_HZ > 150000000) begin : g_bad_clk_hz
    $error("power_sequencer_fsm: CLK_HZ out of range 1000..150000000");
  end

  if (NUM_RAILS < 1 || NUM_RAILS > 8) begin : g_bad_num_rails
    $error("power_sequencer_fsm: NUM_RAILS out of range 1..8");
  end

  typedef enum logic [3:0] {
    HOLD    = 4'd0,
    LATCH   = 4'd1,
    SEQ_UP  = 4'd2,
    REL     = 4'd3,
    RUN     = 4'd4,
    SEQ_DN  = 4'd5,
    FAULT   = 4'd6,
    UNLATCH = 4'd7
  } state_t;

  state_t               state;
  logic [31:0]          cnt;
  logic [2:0]           idx;
  logic                 phase;
  logic [NUM_RAILS-1:0] cur_bit;
  logic [NUM_RAILS-1:0] lost;
  logic [2:0]           lost_idx;

  // True on the last cycle of a wait of t cycles; a zero-length wait expires at once.
  function automatic logic expired(input logic [31:0] c, input logic [31:0] t);
    return (c + 32'd1) >= t;
  endfunction

  // Current rail as a one-hot mask, and the lowest enabled rail that has lost power-good.
  always_comb begin
    cur_bit  = NUM_RAILS'(1) << idx;
    lost     = rail_en & ~pgood;
    lost_idx = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (lost[i]) lost_idx = 3'(i);
    end
  end

  // Sequencer: one registered FSM driving every output directly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      phase      <= 1'b0;
      fd_clk     <= 1'b0;
      fd_dat     <= 1'b0;
      rail_en    <= '0;
      pwr_ready  <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (expired(cnt, T_ON)) begin
            state  <= LATCH;
            cnt    <= '0;
            phase  <= 1'b0;
            fd_dat <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        LATCH: begin
          if (expired(cnt, T_FD)) begin
            cnt <= '0;
            if (!phase) begin
              fd_clk <= 1'b1;
              phase  <= 1'b1;
            end else begin
              fd_clk     <= 1'b0;
              phase      <= 1'b0;
              idx        <= '0;
              rail_en[0] <= 1'b1;
              state      <= SEQ_UP;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        SEQ_UP: begin
          if (!phase) begin
            if (|(pgood & cur_bit)) begin
              cnt <= '0;
              if (T_STEP != 32'd0) begin
                phase <= 1'b1;
              end else if (idx == LAST_RAIL) begin
                state <= REL;
              end else begin
                idx     <= idx + 3'd1;
                rail_en <= rail_en | (cur_bit << 1);
              end
            end else if (expired(cnt, T_PG)) begin
              fault      <= 1'b1;
              fault_rail <= idx;
              state      <= FAULT;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else if (expired(cnt, T_STEP)) begin
            cnt   <= '0;
            phase <= 1'b0;
            if (idx == LAST_RAIL) begin
              state <= REL;
            end else begin
              idx     <= idx + 3'd1;
              rail_en <= rail_en | (cur_bit << 1);
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        REL: begin
          if (!btn_pressed) begin
            state     <= RUN;
            pwr_ready <= 1'b1;
            cnt       <= '0;
          end
        end

        RUN: begin
          if (|lost) begin
            fault      <= 1'b1;
            fault_rail <= lost_idx;
            pwr_ready  <= 1'b0;
            state      <= FAULT;
          end else if (pwr_off_req || (btn_pressed && expired(cnt, T_OFF))) begin
            pwr_ready <= 1'b0;
            state     <= SEQ_DN;
            idx       <= LAST_RAIL;
            phase     <= 1'b0;
            cnt       <= '0;
          end else if (btn_pressed) begin
            cnt <= cnt + 32'd1;
          end else begin
            cnt <= '0;
          end
        end

        SEQ_DN: begin
          if (!phase) begin
            rail_en <= rail_en & ~cur_bit;
            phase   <= 1'b1;
            cnt     <= '0;
          end else if (expired(cnt, T_STEP)) begin
            cnt <= '0;
            if (idx == 3'd0) begin
              state  <= UNLATCH;
              fd_dat <= 1'b0;
              phase  <= 1'b0;
            end else begin
              idx     <= idx - 3'd1;
              rail_en <= rail_en & ~(cur_bit >> 1);
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        FAULT: begin
          rail_en <= '0;
          fd_dat  <= 1'b0;
          cnt     <= '0;
          state   <= UNLATCH;
        end

        UNLATCH: begin
          if (expired(cnt, T_FD)) begin
            fd_clk <= ~fd_clk;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          rail_en   <= '0;
          fd_dat    <= 1'b0;
          pwr_ready <= 1'b0;
          cnt       <= '0;
          state     <= UNLATCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_sequencer_fsm.sv
// tb_power_sequencer_fsm
// Self-checking bench: rail_en transitions are checked against a scoreboard
// queue filled as each scenario is driven; timing points are checked inline.
module tb_power_sequencer_fsm;

  localparam int NR = 3;
  localparam int PG_DELAY = 20;

  logic          clk = 1'b0;
  logic          resetn;
  logic          btn_pressed;
  logic          pwr_off_req;
  logic [NR-1:0] pgood;
  logic          fd_clk;
  logic          fd_dat;
  logic [NR-1:0] rail_en;
  logic          pwr_ready;
  logic          fault;
  logic [2:0]    fault_rail;

  int            vectors = 0;
  int            miscompares = 0;
  logic [2:0]    exp_q[$];
  logic [2:0]    prev_rail = '0;
  logic          prev_fdclk = 1'b0;
  int            fd_rises = 0;
  int            on_cnt[NR];
  logic [NR-1:0] stuck = '0;
  logic [NR-1:0] drop = '0;

  power_sequencer_fsm #(
    .CLK_HZ           (1000000),
    .NUM_RAILS        (NR),
    .ON_PRESS_MS      (1),
    .OFF_PRESS_MS     (5),
    .RAIL_STEP_US     (10),
    .PGOOD_TIMEOUT_MS (1),
    .FD_SETUP_HOLD_CYC(4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_pressed(btn_pressed),
    .pwr_off_req(pwr_off_req),
    .pgood      (pgood),
    .fd_clk     (fd_clk),
    .fd_dat     (fd_dat),
    .rail_en    (rail_en),
    .pwr_ready  (pwr_ready),
    .fault      (fault),
    .fault_rail (fault_rail)
  );

  // 100 MHz nominal bench clock; only cycle counts matter.
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Power-good model: each rail reports good PG_DELAY cycles after its enable, unless stuck or dropped.
  task automatic refreshPgood();
    for (int i = 0; i < NR; i++)
      pgood[i] = (on_cnt[i] >= PG_DELAY) && !stuck[i] && !drop[i];
  endtask

  // Advance whole clock cycles, sampling 1 time unit after each rising edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        on_cnt[i] = (rail_en[i] === 1'b1) ? on_cnt[i] + 1 : 0;
      refreshPgood();
    end
  endtask

  // Scoreboard monitor: every rail_en change must match the next queued value.
  always @(negedge clk) begin
    if (!$isunknown(rail_en) && rail_en !== prev_rail) begin
      if (exp_q.size() == 0)
        checkOutput("rail_unexpected", 32'(rail_en), 32'(prev_rail));
      else
        checkOutput("rail_seq", 32'(rail_en), 32'(exp_q.pop_front()));
      prev_rail = rail_en;
    end
    if (fd_clk === 1'b1 && prev_fdclk === 1'b0) fd_rises++;
    prev_fdclk = fd_clk;
  end

  // Absolute time limit so a stuck design cannot hang the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetValues();
    checkOutput("rst_fd_clk", 32'(fd_clk), 32'd0);
    checkOutput("rst_fd_dat", 32'(fd_dat), 32'd0);
    checkOutput("rst_rail_en", 32'(rail_en), 32'd0);
    checkOutput("rst_pwr_ready", 32'(pwr_ready), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_fault_rail", 32'(fault_rail), 32'd0);
  endtask

  task automatic doReset();
    resetn      = 1'b0;
    btn_pressed = 1'b0;
    pwr_off_req = 1'b0;
    stuck       = '0;
    drop        = '0;
    applyStimulus(5);
    resetn      = 1'b1;
    btn_pressed = 1'b1;
  endtask

  // From reset release with the button held: main power latch and first rail enable.
  task automatic latchCheck();
    int n;
    for (n = 1; n <= 2000; n++) begin applyStimulus(1); if (fd_dat === 1'b1) break; end
    checkOutput("hold_cycles", 32'(n), 32'd1000);
    for (n = 1; n <= 20; n++) begin applyStimulus(1); if (fd_clk === 1'b1) break; end
    checkOutput("fd_setup", 32'(n), 32'd4);
    for (n = 1; n <= 20; n++) begin applyStimulus(1); if (fd_clk === 1'b0) break; end
    checkOutput("fd_pulse", 32'(n), 32'd4);
    checkOutput("rail0_on", 32'(rail_en), 32'd1);
  endtask

  // Remaining rails, then button release into RUN.
  task automatic rampToRun();
    int n;
    for (n = 1; n <= 200; n++) begin applyStimulus(1); if (rail_en[1] === 1'b1) break; end
    checkOutput("gap01_ge30", 32'(n >= 30 && n <= 200), 32'd1);
    for (n = 1; n <= 200; n++) begin applyStimulus(1); if (rail_en[2] === 1'b1) break; end
    checkOutput("gap12_ge30", 32'(n >= 30 && n <= 200), 32'd1);
    applyStimulus(100);
    checkOutput("rel_not_ready", 32'(pwr_ready), 32'd0);
    btn_pressed = 1'b0;
    for (n = 1; n <= 10; n++) begin applyStimulus(1); if (pwr_ready === 1'b1) break; end
    checkOutput("ready_latency", 32'(n), 32'd1);
    checkOutput("run_rails", 32'(rail_en), 32'd7);
  endtask

  initial begin
    int n;
    int rises;
    for (int i = 0; i < NR; i++) on_cnt[i] = 0;
    pgood       = '0;
    resetn      = 1'b0;
    btn_pressed = 1'b0;
    pwr_off_req = 1'b0;

    // 1: reset values, power-up with the button held, RUN only after release
    applyStimulus(5);
    checkResetValues();
    resetn      = 1'b1;
    btn_pressed = 1'b1;
    exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b111);
    latchCheck();
    rampToRun();
    checkOutput("run_fault", 32'(fault), 32'd0);

    // 2: one-cycle soft off request, reverse teardown and free-running fd_clk
    exp_q.push_back(3'b011); exp_q.push_back(3'b001); exp_q.push_back(3'b000);
    pwr_off_req = 1'b1;
    applyStimulus(1);
    pwr_off_req = 1'b0;
    checkOutput("dn_ready_drop", 32'(pwr_ready), 32'd0);
    checkOutput("dn_rails_held", 32'(rail_en), 32'd7);
    for (n = 1; n <= 50; n++) begin applyStimulus(1); if (rail_en === 3'b011) break; end
    checkOutput("dn_first", 32'(n), 32'd1);
    for (n = 1; n <= 50; n++) begin applyStimulus(1); if (rail_en === 3'b001) break; end
    checkOutput("dn_gap_1", 32'(n), 32'd10);
    for (n = 1; n <= 50; n++) begin applyStimulus(1); if (rail_en === 3'b000) break; end
    checkOutput("dn_gap_0", 32'(n), 32'd10);
    for (n = 1; n <= 50; n++) begin applyStimulus(1); if (fd_dat === 1'b0) break; end
    checkOutput("unlatch_delay", 32'(n), 32'd10);
    for (n = 1; n <= 20; n++) begin applyStimulus(1); if (fd_clk === 1'b1) break; end
    checkOutput("ul_toggle_1", 32'(n), 32'd4);
    for (n = 1; n <= 20; n++) begin applyStimulus(1); if (fd_clk === 1'b0) break; end
    checkOutput("ul_toggle_2", 32'(n), 32'd4);
    for (n = 1; n <= 20; n++) begin applyStimulus(1); if (fd_clk === 1'b1) break; end
    checkOutput("ul_toggle_3", 32'(n), 32'd4);

    // 3: long-press boundary, 4999 cycles ignored, 5000 cycles shuts down
    doReset();
    exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b111);
    latchCheck();
    rampToRun();
    btn_pressed = 1'b1;
    applyStimulus(4999);
    btn_pressed = 1'b0;
    checkOutput("hold_4999_ready", 32'(pwr_ready), 32'd1);
    applyStimulus(1);
    checkOutput("release_ready", 32'(pwr_ready), 32'd1);
    exp_q.push_back(3'b011); exp_q.push_back(3'b001); exp_q.push_back(3'b000);
    btn_pressed = 1'b1;
    applyStimulus(4999);
    checkOutput("hold_pre_ready", 32'(pwr_ready), 32'd1);
    applyStimulus(1);
    checkOutput("hold_5000_ready", 32'(pwr_ready), 32'd0);
    btn_pressed = 1'b0;
    applyStimulus(60);
    checkOutput("press_off_rails", 32'(rail_en), 32'd0);
    checkOutput("press_off_fd_dat", 32'(fd_dat), 32'd0);

    // 4: rail 1 never reports good, timeout fault
    doReset();
    stuck[1] = 1'b1;
    exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b000);
    latchCheck();
    for (n = 1; n <= 200; n++) begin applyStimulus(1); if (rail_en[1] === 1'b1) break; end
    for (n = 1; n <= 1100; n++) begin applyStimulus(1); if (fault === 1'b1) break; end
    checkOutput("pg_timeout", 32'(n), 32'd1000);
    checkOutput("to_fault_rail", 32'(fault_rail), 32'd1);
    checkOutput("to_rails_held", 32'(rail_en), 32'd3);
    applyStimulus(1);
    checkOutput("to_rails_off", 32'(rail_en), 32'd0);
    checkOutput("to_fd_dat", 32'(fd_dat), 32'd0);
    applyStimulus(20);
    checkOutput("fault_sticky", 32'(fault), 32'd1);
    checkOutput("fault_no_ready", 32'(pwr_ready), 32'd0);

    // 5: pgood loss coinciding with an off request, fault wins
    doReset();
    exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b111);
    exp_q.push_back(3'b000);
    latchCheck();
    rampToRun();
    drop[2] = 1'b1;
    refreshPgood();
    pwr_off_req = 1'b1;
    applyStimulus(1);
    pwr_off_req = 1'b0;
    checkOutput("race_fault", 32'(fault), 32'd1);
    checkOutput("race_fault_rail", 32'(fault_rail), 32'd2);
    checkOutput("race_ready", 32'(pwr_ready), 32'd0);
    checkOutput("race_rails_held", 32'(rail_en), 32'd7);
    applyStimulus(1);
    checkOutput("race_rails_off", 32'(rail_en), 32'd0);

    // 6: reset in the middle of power-up, then a full restart
    doReset();
    exp_q.push_back(3'b001);
    latchCheck();
    applyStimulus(5);
    exp_q.push_back(3'b000);
    rises  = fd_rises;
    resetn = 1'b0;
    applyStimulus(1);
    checkResetValues();
    applyStimulus(3);
    checkOutput("rst_no_fd_rise", 32'(fd_rises), 32'(rises));
    resetn      = 1'b1;
    btn_pressed = 1'b1;
    exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b111);
    latchCheck();
    rampToRun();

    applyStimulus(2);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
